op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter RES_W, default 6: width of each unit result and of result.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: number of RUN cycles allowed before abort (used only with SEQ_TIMEOUT_EN).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 go  in  1  raw pushbutton level, asynchronous to clk.
REQ-006 op_sel  in  3  operation code: 000 add, 001 sub, 010 mul, 011 div, 100 shift-right; 101-111 illegal.
REQ-007 unit_done  in  5  done flag per unit, bit index = op code.
REQ-008 unit_res  in  5*RES_W  flattened unit results; unit i occupies bits [i*RES_W +: RES_W].
REQ-009 init  out  5  one-hot level enable to selected unit.
REQ-010 result  out  RES_W  last captured result.
REQ-011 busy  out  1  high while an operation is in flight.
REQ-012 valid  out  1  result holds a completed operation.
REQ-013 err  out  1  last request was illegal or timed out.

Function
REQ-014 go SHALL pass a 2-flop synchroniser plus a history flop; a launch request is a single-cycle pulse on synchronised 0->1.
REQ-015 FSM states SHALL be IDLE, LAUNCH, RUN, CAPTURE.
REQ-016 IDLE: busy=0, init=0; on request pulse, op_sel is latched into op_q in that cycle.
REQ-017 IDLE, request with legal op_sel: next state LAUNCH.
REQ-018 IDLE, request with illegal op_sel: err<=1, valid unchanged, result unchanged, remain IDLE.
REQ-019 LAUNCH (one cycle): valid<=0, err<=0, init[op_q]=1, busy=1, unit_done ignored; next RUN.
REQ-020 RUN: init[op_q] held at 1, busy=1; when unit_done[op_q]=1, next CAPTURE; done bits of other units ignored.
REQ-021 CAPTURE (one cycle): result<=unit_res slice op_q, valid<=1, init=0, busy=1; next IDLE.
REQ-022 Latency: init[op_q] first high 3 cycles after the first clk edge sampling go=1; result/valid update one cycle after the RUN cycle in which unit_done[op_q]=1.
REQ-023 Request pulses occurring while busy=1 SHALL be dropped, not queued.
REQ-024 init SHALL never have more than one bit set; init=0 in every state except LAUNCH and RUN.
REQ-025 op_sel changes after latching SHALL not affect the operation in flight.

Reset
REQ-026 rst SHALL force state IDLE, init=0, busy=0, valid=0, err=0, result=0, op_q=0, timeout counter=0.
REQ-027 Synchroniser and history flops SHALL reset to 1, so a button held through reset release causes no launch until released and re-pressed.
REQ-028 rst asserted mid-operation SHALL abort in the same clock edge; no capture occurs.

Configuration
REQ-029 Macro SEQ_TIMEOUT_EN defined: an 8-bit-minimum counter clears on LAUNCH and increments each RUN cycle; after TIMEOUT_CYCLES RUN cycles without done, init<=0, err<=1, valid stays 0, result unchanged, next IDLE.
REQ-030 Macro SEQ_TIMEOUT_EN undefined: no counter is built; RUN waits indefinitely; err is set only by illegal op codes.
REQ-031 When done and timeout coincide in the same cycle, done SHALL win (CAPTURE).

Verification
REQ-032 rst, op_sel=100, unit_res[4]=6'h05, press go, unit_done[4] 4 cycles after init -> init=5'b10000 during run, then result=6'h05, valid=1, err=0, busy=0.
REQ-033 op_sel=110, press go -> err=1, init stays 0, busy stays 0, result unchanged.
REQ-034 op 010 running, press go again with op_sel=000 -> second press dropped, init stays 5'b00100, only mul result captured.
REQ-035 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, op 011, unit_done never asserted -> init drops after 10 RUN cycles, err=1, valid=0.
REQ-036 go held high across rst deassertion -> no launch; release then press -> exactly one launch.
REQ-037 rst pulsed during RUN of op 001 -> next cycle init=0, busy=0, valid=0, result=0.

Source files
------------

// File: rtl/op_sequencer.sv
// Operation sequencer: debounced-free pushbutton launch of one of five arithmetic units, result capture.
// Optional RUN-phase timeout abort is built when SEQ_TIMEOUT_EN is defined.
module op_sequencer #(
  parameter int unsigned RES_W          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [2:0]           op_sel,
  input  logic [4:0]           unit_done,
  input  logic [5*RES_W-1:0]   unit_res,
  output logic [4:0]           init,
  output logic [RES_W-1:0]     result,
  output logic                 busy,
  output logic                 valid,
  output logic                 err
);

  localparam int unsigned N_UNITS = 5;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_CAPTURE} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                r_state, w_state_nx;
  logic                  r_sync1, r_sync2, r_hist, r_req;
  logic [OP_W-1:0]       r_op_q, w_op_nx;
  logic [RES_W-1:0]      w_result_nx, w_res;
  logic                  w_valid_nx, w_err_nx, w_busy_nx, w_done, w_legal;
  logic [N_UNITS-1:0]    w_init_nx;

  // Synchroniser and history reset high so a button held through reset never launches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
      r_req   <= 1'b0;
    end else begin
      r_sync1 <= go;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_req   <= r_sync2 & ~r_hist;
    end
  end

  assign w_legal = (op_sel < OP_W'(N_UNITS));

  // Select done flag and result of the unit named by the latched op code.
  always_comb begin
    w_done = 1'b0;
    w_res  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (r_op_q == OP_W'(i)) begin
        w_done = unit_done[i];
        w_res  = unit_res[i*RES_W +: RES_W];
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr, w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc)   r_cnt <= r_cnt + CNT_W'(1);
  end
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_op_nx     = r_op_q;
    w_result_nx = result;
    w_valid_nx  = valid;
    w_err_nx    = err;
`ifdef SEQ_TIMEOUT_EN
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (r_req) begin
          w_op_nx = op_sel;
          if (w_legal) w_state_nx = S_LAUNCH;
          else         w_err_nx   = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_state_nx = S_RUN;
`ifdef SEQ_TIMEOUT_EN
        w_cnt_clr  = 1'b1;
`endif
      end
      S_RUN: begin
        // Done takes priority over a coincident timeout.
        if (w_done) begin
          w_state_nx = S_CAPTURE;
`ifdef SEQ_TIMEOUT_EN
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_inc  = 1'b1;
`endif
        end
      end
      S_CAPTURE: begin
        w_result_nx = w_res;
        w_valid_nx  = 1'b1;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
    w_init_nx = ((w_state_nx == S_LAUNCH) || (w_state_nx == S_RUN))
              ? (N_UNITS'(1) << w_op_nx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
      init    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op_q  <= w_op_nx;
      init    <= w_init_nx;
      result  <= w_result_nx;
      busy    <= w_busy_nx;
      valid   <= w_valid_nx;
      err     <= w_err_nx;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: launch latency, illegal ops, dropped presses, reset behaviour, timeout.
module tb_op_sequencer;
  localparam int unsigned RES_W = 6;

  logic               clk = 1'b0;
  logic               rst, go;
  logic [2:0]         op_sel;
  logic [4:0]         unit_done;
  logic [5*RES_W-1:0] unit_res;
  logic [4:0]         init;
  logic [RES_W-1:0]   result;
  logic               busy, valid, err;

  int checks = 0;
  int errors = 0;

  op_sequencer #(.RES_W(RES_W), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .go(go), .op_sel(op_sel), .unit_done(unit_done),
    .unit_res(unit_res), .init(init), .result(result), .busy(busy),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; op_sel = 3'd0; unit_done = '0;
    unit_res = {6'h05, 6'h2A, 6'h33, 6'h22, 6'h11};
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_init", 32'(init), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    step(4);

    // Shift-right op: launch latency, other done bits ignored, capture.
    op_sel = 3'd4; go = 1'b1;
    step(3);
    chk("lat_init_early", 32'(init), 32'h0);
    chk("lat_busy_early", 32'(busy), 32'h0);
    step(1);
    chk("lat_init", 32'(init), 32'h10);
    chk("lat_busy", 32'(busy), 32'h1);
    go = 1'b0;
    step(1);
    unit_done = 5'b01111;
    step(3);
    chk("run_other_done", 32'(init), 32'h10);
    unit_done = 5'b10000;
    step(1);
    chk("cap_init", 32'(init), 32'h0);
    chk("cap_busy", 32'(busy), 32'h1);
    chk("cap_valid_pre", 32'(valid), 32'h0);
    unit_done = '0;
    step(1);
    chk("shr_result", 32'(result), 32'h05);
    chk("shr_valid", 32'(valid), 32'h1);
    chk("shr_err", 32'(err), 32'h0);
    chk("shr_busy", 32'(busy), 32'h0);
    step(3);

    // Illegal op code.
    op_sel = 3'd6; go = 1'b1;
    step(3);
    chk("ill_err_early", 32'(err), 32'h0);
    step(1);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_init", 32'(init), 32'h0);
    chk("ill_busy", 32'(busy), 32'h0);
    chk("ill_result", 32'(result), 32'h05);
    chk("ill_valid", 32'(valid), 32'h1);
    go = 1'b0;
    step(3);

    // Mul op with a second press while busy.
    op_sel = 3'd2; go = 1'b1;
    step(4);
    chk("mul_init", 32'(init), 32'h04);
    go = 1'b0;
    step(1);
    chk("mul_err_clr", 32'(err), 32'h0);
    chk("mul_valid_clr", 32'(valid), 32'h0);
    step(3);
    op_sel = 3'd0; go = 1'b1;
    step(5);
    chk("drop_init", 32'(init), 32'h04);
    chk("drop_busy", 32'(busy), 32'h1);
    go = 1'b0;
    step(3);
    unit_done = 5'b00101;
    step(1);
    unit_done = '0;
    step(1);
    chk("mul_result", 32'(result), 32'h33);
    chk("mul_valid", 32'(valid), 32'h1);
    step(5);
    chk("drop_no_relaunch", 32'(init), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);

    // Button held across reset release.
    op_sel = 3'd1; go = 1'b1; rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);
    chk("held_no_launch", 32'(init), 32'h0);
    chk("held_no_busy", 32'(busy), 32'h0);
    go = 1'b0;
    step(3);
    go = 1'b1;
    step(4);
    chk("repress_launch", 32'(init), 32'h02);
    step(2);
    chk("repress_run", 32'(init), 32'h02);

    // Reset during RUN aborts with no capture.
    unit_done = 5'b00010;
    rst = 1'b1;
    step(1);
    chk("abort_init", 32'(init), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_valid", 32'(valid), 32'h0);
    chk("abort_result", 32'(result), 32'h0);
    rst = 1'b0;
    unit_done = '0;
    step(5);
    chk("abort_no_relaunch", 32'(busy), 32'h0);
    go = 1'b0;
    step(3);

    // Div op with no done: timeout when built, indefinite wait otherwise.
    op_sel = 3'd3; go = 1'b1;
    step(4);
    chk("div_init", 32'(init), 32'h08);
    go = 1'b0;
    step(10);
    chk("div_run10", 32'(init), 32'h08);
    step(1);
`ifdef SEQ_TIMEOUT_EN
    chk("to_init", 32'(init), 32'h0);
    chk("to_err", 32'(err), 32'h1);
    chk("to_valid", 32'(valid), 32'h0);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_result", 32'(result), 32'h0);
`else
    chk("wait_init", 32'(init), 32'h08);
    chk("wait_err", 32'(err), 32'h0);
    step(20);
    chk("wait_long", 32'(busy), 32'h1);
    unit_done = 5'b01000;
    step(1);
    unit_done = '0;
    step(1);
    chk("div_result", 32'(result), 32'h2A);
    chk("div_valid", 32'(valid), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
